// File: rtl/rr_pkg.sv
// Shared width, default thresholds and state type for the RR window statistics block.
package rr_pkg;

  localparam int RR_W         = 16;
  localparam int RR_MIN_DEF   = 30;
  localparam int RR_MAX_DEF   = 200;
  localparam int DIFF_THR_DEF = 12;
  localparam int GAP_MAX_DEF  = 300;

  typedef enum logic [1:0] {PRIME, FILL, RUN} rr_state_e;

endpackage

// File: rtl/rr_ring_sum.sv
// Circular buffer of 2^DEPTH_LOG2 entries with a running sum of its contents.
module rr_ring_sum
  import rr_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [RR_W-1:0]            data_in,
  output logic [RR_W+DEPTH_LOG2-1:0] sum,
  output logic [RR_W-1:0]            oldest
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = RR_W + DEPTH_LOG2;

  logic [RR_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;

  // The slot about to be overwritten is the oldest one; unfilled slots read as 0.
  assign oldest = mem[wr_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (push) begin
      mem[wr_ptr] <= data_in;
      wr_ptr      <= wr_ptr + 1'b1;
      sum         <= sum + SUM_W'(data_in) - SUM_W'(oldest);
    end
  end

endmodule

// File: rtl/rr_window_stats.sv
// Sliding-window RR mean / mean successive difference with apnea-candidate flag.
// Optional gap alarm enabled by defining RR_GAP_ALARM_EN.
module rr_window_stats
  import rr_pkg::*;
#(
  parameter int WIN_LOG2 = 3,
  parameter int RR_MIN   = RR_MIN_DEF,
  parameter int RR_MAX   = RR_MAX_DEF,
  parameter int DIFF_THR = DIFF_THR_DEF,
  parameter int GAP_MAX  = GAP_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic            rr_valid,
  input  logic [RR_W-1:0] rr_value,
  output logic            stats_valid,
  output logic [RR_W-1:0] rr_mean,
  output logic [RR_W-1:0] rr_msd,
  output logic            apnea_flag,
  output logic            window_full,
  output logic [7:0]      reject_cnt,
  output logic            gap_alarm
);

  localparam int SUM_W = RR_W + WIN_LOG2;
  localparam int DEPTH = 1 << WIN_LOG2;

  rr_state_e         state;
  logic [WIN_LOG2:0] fill_cnt;
  logic [RR_W-1:0]   prev_rr, s1_rr, s1_diff, abs_diff;
  logic              s1_push, s1_full;
  logic              accept, gap_hit;
  logic [SUM_W-1:0]  rr_sum, diff_sum, rr_sum_next, diff_sum_next;
  logic [RR_W-1:0]   rr_oldest, diff_oldest, msd_next;

  assign accept   = rr_valid && (rr_value >= RR_W'(RR_MIN)) && (rr_value <= RR_W'(RR_MAX));
  assign abs_diff = (rr_value >= prev_rr) ? rr_value - prev_rr : prev_rr - rr_value;

`ifdef RR_GAP_ALARM_EN
  logic [15:0] gap_cnt;

  // A strobe on the same cycle always wins over the gap reaching its limit.
  assign gap_hit = !rr_valid && sample_en && (gap_cnt == 16'(GAP_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt   <= '0;
      gap_alarm <= 1'b0;
    end else begin
      if (rr_valid) gap_cnt <= '0;
      else if (sample_en && gap_cnt != 16'(GAP_MAX)) gap_cnt <= gap_cnt + 16'd1;
      if (gap_hit) gap_alarm <= 1'b1;
      else if (accept) gap_alarm <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = sample_en ^ (GAP_MAX == 0);
  assign gap_hit    = 1'b0;
  assign gap_alarm  = 1'b0;
`endif

  // Stage 1: range check, difference against the previous accepted RR, fill tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIME;
      fill_cnt   <= '0;
      prev_rr    <= '0;
      s1_rr      <= '0;
      s1_diff    <= '0;
      s1_push    <= 1'b0;
      s1_full    <= 1'b0;
      reject_cnt <= '0;
    end else begin
      s1_push <= 1'b0;
      if (rr_valid && !accept && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
      if (gap_hit) begin
        state    <= PRIME;
        fill_cnt <= '0;
        prev_rr  <= '0;
        s1_full  <= 1'b0;
      end else if (accept) begin
        prev_rr <= rr_value;
        s1_rr   <= rr_value;
        s1_diff <= abs_diff;
        case (state)
          PRIME: state <= FILL;
          FILL: begin
            s1_push  <= 1'b1;
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == (WIN_LOG2+1)'(DEPTH - 1)) begin
              state   <= RUN;
              s1_full <= 1'b1;
            end else begin
              s1_full <= 1'b0;
            end
          end
          RUN: begin
            s1_push <= 1'b1;
            s1_full <= 1'b1;
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

  rr_ring_sum #(.DEPTH_LOG2(WIN_LOG2)) u_rr_ring (
    .clk(clk), .rst(rst), .clear(gap_hit), .push(s1_push),
    .data_in(s1_rr), .sum(rr_sum), .oldest(rr_oldest)
  );

  rr_ring_sum #(.DEPTH_LOG2(WIN_LOG2)) u_diff_ring (
    .clk(clk), .rst(rst), .clear(gap_hit), .push(s1_push),
    .data_in(s1_diff), .sum(diff_sum), .oldest(diff_oldest)
  );

  assign rr_sum_next   = rr_sum + SUM_W'(s1_rr) - SUM_W'(rr_oldest);
  assign diff_sum_next = diff_sum + SUM_W'(s1_diff) - SUM_W'(diff_oldest);
  assign msd_next      = RR_W'(diff_sum_next >> WIN_LOG2);

  // Stage 2: outputs follow the sums as they stand after this push.
  always_ff @(posedge clk) begin
    if (rst || gap_hit) begin
      stats_valid <= 1'b0;
      rr_mean     <= '0;
      rr_msd      <= '0;
      apnea_flag  <= 1'b0;
      window_full <= 1'b0;
    end else begin
      stats_valid <= s1_push && s1_full;
      if (s1_push) window_full <= s1_full;
      if (s1_push && s1_full) begin
        rr_mean    <= RR_W'(rr_sum_next >> WIN_LOG2);
        rr_msd     <= msd_next;
        apnea_flag <= (msd_next >= RR_W'(DIFF_THR));
      end
    end
  end

endmodule

// File: tb/tb_rr_window_stats.sv
// Self-checking bench for rr_window_stats: vector table, corner sequences, random vs queue model.
module tb_rr_window_stats;

  localparam int DIFF_THR = 12;
`ifdef RR_GAP_ALARM_EN
  localparam int GAP_MAX = 300;
`endif

  logic        clk = 1'b0;
  logic        rst, sample_en, rr_valid;
  logic [15:0] rr_value;
  logic        stats_valid, apnea_flag, window_full, gap_alarm;
  logic [15:0] rr_mean, rr_msd;
  logic [7:0]  reject_cnt;

  always #5 clk = ~clk;

  rr_window_stats dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rr_valid(rr_valid),
    .rr_value(rr_value), .stats_valid(stats_valid), .rr_mean(rr_mean),
    .rr_msd(rr_msd), .apnea_flag(apnea_flag), .window_full(window_full),
    .reject_cnt(reject_cnt), .gap_alarm(gap_alarm)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: the accepted history as queues, results delayed to their visible cycle.
  int rr_q[$];
  int df_q[$];
  bit m_have_prev;
  int m_prev, m_rej, m_gap;
  bit pend_push, pend_pulse;
  int pend_mean, pend_msd;
  bit exp_sv, exp_flag, exp_full, exp_gap;
  int exp_mean, exp_msd;

  typedef struct {
    int val;
    int rej;
    bit chk;
    bit full;
    int mean;
    int msd;
    bit flag;
  } vec_t;

  vec_t tbl[29];

  task automatic modelReset();
    rr_q.delete();
    df_q.delete();
    m_have_prev = 0; m_prev = 0; m_rej = 0; m_gap = 0;
    pend_push = 0; pend_pulse = 0; pend_mean = 0; pend_msd = 0;
    exp_sv = 0; exp_flag = 0; exp_full = 0; exp_gap = 0; exp_mean = 0; exp_msd = 0;
  endtask

  task automatic modelEdge(input bit v, input int val, input bit se, input bit r);
    int s;
    if (r) begin
      modelReset();
      return;
    end
    exp_sv = pend_pulse;
    if (pend_push) exp_full = pend_pulse;
    if (pend_pulse) begin
      exp_mean = pend_mean;
      exp_msd  = pend_msd;
      exp_flag = (pend_msd >= DIFF_THR);
    end
    pend_push = 0;
    pend_pulse = 0;
`ifdef RR_GAP_ALARM_EN
    if (v) m_gap = 0;
    else if (se && m_gap < GAP_MAX) begin
      m_gap++;
      if (m_gap == GAP_MAX) begin
        rr_q.delete();
        df_q.delete();
        m_have_prev = 0;
        exp_sv = 0; exp_mean = 0; exp_msd = 0; exp_flag = 0; exp_full = 0; exp_gap = 1;
      end
    end
`endif
    if (v) begin
      if (val >= 30 && val <= 200) begin
`ifdef RR_GAP_ALARM_EN
        exp_gap = 0;
`endif
        if (!m_have_prev) m_have_prev = 1;
        else begin
          rr_q.push_back(val);
          df_q.push_back(val > m_prev ? val - m_prev : m_prev - val);
          if (rr_q.size() > 8) begin
            void'(rr_q.pop_front());
            void'(df_q.pop_front());
          end
          pend_push  = 1;
          pend_pulse = (rr_q.size() == 8);
          s = 0;
          foreach (rr_q[i]) s += rr_q[i];
          pend_mean = s / 8;
          s = 0;
          foreach (df_q[i]) s += df_q[i];
          pend_msd = s / 8;
        end
        m_prev = val;
      end else if (m_rej < 255) m_rej++;
    end
  endtask

  task automatic checkField(input string name, input logic [15:0] act, input int expv);
    checks++;
    if (act !== 16'(expv)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic checkOutput();
    checkField("stats_valid", {15'd0, stats_valid}, int'(exp_sv));
    checkField("rr_mean", rr_mean, exp_mean);
    checkField("rr_msd", rr_msd, exp_msd);
    checkField("apnea_flag", {15'd0, apnea_flag}, int'(exp_flag));
    checkField("window_full", {15'd0, window_full}, int'(exp_full));
    checkField("reject_cnt", {8'd0, reject_cnt}, m_rej);
    checkField("gap_alarm", {15'd0, gap_alarm}, int'(exp_gap));
    if (stats_valid === 1'b1) pulses++;
  endtask

  task automatic applyStimulus(input bit v, input int val, input bit se, input bit r);
    rr_valid  = v;
    rr_value  = 16'(val);
    sample_en = se;
    rst       = r;
    @(posedge clk);
    modelEdge(v, val, se, r);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = '{80, 0, 1, 0, 0, 0, 0};
    tbl[3] = '{20, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{250, 2, 1, 0, 0, 0, 0};
    for (int i = 5; i < 10; i++) tbl[i] = '{80, 2, 1, 0, 0, 0, 0};
    tbl[10] = '{80, 2, 1, 1, 80, 0, 0};
    for (int k = 0; k < 9; k++) tbl[11+k] = '{(k % 2 == 0) ? 70 : 90, 2, 0, 1, 0, 0, 0};
    tbl[19] = '{70, 2, 1, 1, 80, 20, 1};
    for (int k = 0; k < 9; k++) tbl[20+k] = '{80, 2, 0, 1, 0, 0, 0};
    tbl[28] = '{80, 2, 1, 1, 80, 0, 0};

    modelReset();
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    idle(2);

    // Fill with rejects mid-fill, alternating pattern, then settle back to a flat rhythm.
    pulses = 0;
    for (int i = 0; i < 29; i++) begin
      applyStimulus(1, tbl[i].val, 0, 0);
      idle(3);
      checkField($sformatf("tbl%0d_rej", i), {8'd0, reject_cnt}, tbl[i].rej);
      if (tbl[i].chk) begin
        checkField($sformatf("tbl%0d_full", i), {15'd0, window_full}, int'(tbl[i].full));
        checkField($sformatf("tbl%0d_mean", i), rr_mean, tbl[i].mean);
        checkField($sformatf("tbl%0d_msd", i), rr_msd, tbl[i].msd);
        checkField($sformatf("tbl%0d_flag", i), {15'd0, apnea_flag}, int'(tbl[i].flag));
      end
      if (i == 10) checkField("fill_pulses", pulses, 1);
    end

    // Back-to-back strobes with a full window.
    pulses = 0;
    repeat (8) applyStimulus(1, 100, 0, 0);
    idle(2);
    checkField("b2b_pulses", pulses, 8);
    checkField("b2b_mean", rr_mean, 100);
    checkField("b2b_msd", rr_msd, 2);
    checkField("b2b_flag", {15'd0, apnea_flag}, 0);

`ifdef RR_GAP_ALARM_EN
    repeat (299) applyStimulus(0, 0, 1, 0);
    checkField("gap_early", {15'd0, gap_alarm}, 0);
    applyStimulus(0, 0, 1, 0);
    checkField("gap_set", {15'd0, gap_alarm}, 1);
    checkField("gap_full", {15'd0, window_full}, 0);
    checkField("gap_mean", rr_mean, 0);
    applyStimulus(1, 80, 0, 0);
    checkField("gap_clear", {15'd0, gap_alarm}, 0);
    pulses = 0;
    repeat (7) applyStimulus(1, 80, 0, 0);
    idle(2);
    checkField("gap_refill_none", pulses, 0);
    applyStimulus(1, 80, 0, 0);
    idle(2);
    checkField("gap_refill_one", pulses, 1);
`endif

    // Reset mid-fill with a strobe still in the pipeline.
    applyStimulus(0, 0, 0, 1);
    repeat (6) begin
      applyStimulus(1, 90, 0, 0);
      idle(1);
    end
    pulses = 0;
    applyStimulus(1, 90, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkField("rst_full", {15'd0, window_full}, 0);
    checkField("rst_mean", rr_mean, 0);
    checkField("rst_rej", {8'd0, reject_cnt}, 0);
    idle(2);
    checkField("rst_no_pulse", pulses, 0);
    repeat (8) begin
      applyStimulus(1, 90, 0, 0);
      idle(1);
    end
    idle(2);
    checkField("rst_8_none", pulses, 0);
    applyStimulus(1, 90, 0, 0);
    idle(2);
    checkField("rst_9_one", pulses, 1);
    checkField("rst_9_mean", rr_mean, 90);

    // Reject counter saturation.
    repeat (260) applyStimulus(1, 5, 0, 0);
    checkField("rej_sat", {8'd0, reject_cnt}, 255);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(10, 220)),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_window_stats.md
Name: rr_window_stats

Overview:
- Consumes each new RR interval from the RR interval stage, in 100 Hz sample units.
- Rejects non-physiological values.
- Keeps a sliding window of the last 2^WIN_LOG2 accepted intervals and their successive absolute differences.
- Emits window mean, mean successive difference (MSD) and an apnea-candidate flag to the downstream apnea classifier.

Parameters:
- WIN_LOG2, 3, log2 of window depth (8 intervals).
- RR_MIN, 30, minimum accepted RR in samples (0.3 s).
- RR_MAX, 200, maximum accepted RR in samples (2.0 s).
- DIFF_THR, 12, MSD threshold (samples) for apnea_flag.
- GAP_MAX, 300, sample_en count without a beat before gap alarm (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_en  in  1  100 Hz enable; used only with the optional feature
- rr_valid  in  1  one-cycle strobe: new RR available (sample_en & r_peak upstream)
- rr_value  in  16  RR interval in samples
- stats_valid  out  1  one-cycle pulse: new statistics registered
- rr_mean  out  16  window sum >> WIN_LOG2
- rr_msd  out  16  diff-window sum >> WIN_LOG2
- apnea_flag  out  1  rr_msd >= DIFF_THR; held between stats_valid pulses
- window_full  out  1  window holds 2^WIN_LOG2 entries
- reject_cnt  out  8  saturating count of rejected intervals
- gap_alarm  out  1  no beat for GAP_MAX samples; tied 0 without the optional feature

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - All outputs become 0; both ring buffers, sums, prev_rr and state are cleared; in-flight pipeline data is dropped.
  - This applies equally to a reset in the middle of a window.
- Acceptance:
  - Accept when RR_MIN <= rr_value <= RR_MAX.
  - Otherwise, in stage 1: reject_cnt += 1, saturating at 255. prev_rr, state and the buffers are unchanged, and no stats_valid is produced.
- State machine (advances on accepted intervals only):
  - PRIME: no previous RR. An accepted interval loads prev_rr, pushes nothing and goes to FILL.
  - FILL: each accepted interval pushes rr_value and |rr_value - prev_rr|, updates prev_rr and increments fill_cnt. At fill_cnt == 2^WIN_LOG2, go to RUN and set window_full.
  - RUN: each accepted interval pushes both values; the oldest entries are overwritten (circular write pointer, wrap modulo 2^WIN_LOG2).
- Pipeline:
  - Stage 1 (cycle t+1): range check, absolute difference, prev_rr update.
  - Stage 2 (cycle t+2): ring write, sum update (sum <= sum + new - oldest), output registers update.
  - stats_valid pulses at t+2, only if window_full is 1 after that push. This includes the push that fills the window.
- Throughput:
  - rr_valid may be asserted every cycle; every strobe is processed with no stalls.
  - Back-to-back differences use the stage-1 prev_rr.
- Arithmetic:
  - Sums are unsigned, 16+WIN_LOG2 bits wide, and cannot overflow.
  - Mean is a truncating right shift.
  - The difference is an unsigned magnitude.
- Holding: rr_mean, rr_msd and apnea_flag hold their values between pulses. In FILL they stay 0.

Optional Feature:
- Macro: RR_GAP_ALARM_EN.
- When defined:
  - A 16-bit counter increments on sample_en and clears on any rr_valid (accepted or rejected).
  - When the counter reaches GAP_MAX: gap_alarm = 1, state returns to PRIME, fill_cnt = 0, sums and buffers clear, and window_full = 0. rr_mean, rr_msd and apnea_flag clear. reject_cnt is kept.
  - gap_alarm clears on the next accepted interval.
  - If rr_valid coincides with the reaching of GAP_MAX, rr_valid wins.
- When not defined: no counter, gap_alarm tied to 0, sample_en unused.

Decomposition:
- Package rr_pkg:
  - RR_W = 16.
  - Default RR_MIN, RR_MAX, DIFF_THR and GAP_MAX.
  - State enum {PRIME, FILL, RUN}.
- Sub-module rr_ring_sum: 2^WIN_LOG2-deep circular buffer plus running sum, with push, data_in, sum and oldest. It is instantiated twice, once for RR and once for differences.

Test Plan:
1. Nine rr_valid strobes of 80, spaced 100 cycles -> single stats_valid after the 9th strobe (at t+2): rr_mean=80, rr_msd=0, apnea_flag=0, window_full=1.
2. Alternating 70,90 for nine strobes -> rr_mean=80, rr_msd=20, apnea_flag=1. Then nine strobes of 80 -> rr_msd falls to 0 and apnea_flag=0 at the last pulse.
3. Inject 20 and 250 mid-FILL -> reject_cnt=2, no stats_valid, prev_rr unchanged. The next accepted 80 gives diff 0.
4. Window full; rr_valid asserted on 8 consecutive cycles with 100 -> 8 stats_valid pulses on consecutive cycles; final rr_mean=100, rr_msd matches a software model.
5. rst asserted for one cycle while 5 entries are filled, with a strobe in flight -> all outputs 0 next cycle, no stats_valid. Nine more strobes are needed before the next pulse.
6. With RR_GAP_ALARM_EN: window full, then 300 sample_en without rr_valid -> gap_alarm=1, window_full=0, rr_mean=0. The next accepted 80 clears gap_alarm and state is PRIME→FILL.
